// File: rtl/fp_sqrt_digit_pkg.sv
// fp_sqrt_digit_pkg: FSM state encodings and flag packing shared by the square-root unit.
package fp_sqrt_digit_pkg;
    localparam logic [3:0] ST_GET_A   = 4'd0;
    localparam logic [3:0] ST_UNPACK  = 4'd1;
    localparam logic [3:0] ST_SPECIAL = 4'd2;
    localparam logic [3:0] ST_NORM    = 4'd3;
    localparam logic [3:0] ST_PREP    = 4'd4;
    localparam logic [3:0] ST_ITER    = 4'd5;
    localparam logic [3:0] ST_ROUND   = 4'd6;
    localparam logic [3:0] ST_PACK    = 4'd7;
    localparam logic [3:0] ST_PUT_Z   = 4'd8;
    localparam int FLAG_INVALID = 1;
    localparam int FLAG_INEXACT = 0;
    function automatic logic [1:0] mk_flags(input logic invalid, input logic inexact);
        logic [1:0] f;
        f = '0;
        f[FLAG_INVALID] = invalid;
        f[FLAG_INEXACT] = inexact;
        return f;
    endfunction
endpackage

// File: rtl/fp_sqrt_digit_if.sv
// fp_sqrt_digit_if: stb/ack operand and result channels of the square-root unit.
interface fp_sqrt_digit_if #(parameter int EXP_W = 8, parameter int MAN_W = 23);
    localparam int W = 1 + EXP_W + MAN_W;
    logic [W-1:0] input_a;
    logic         input_a_stb;
    logic         input_a_ack;
    logic [W-1:0] output_z;
    logic         output_z_stb;
    logic         output_z_ack;
    logic [1:0]   output_flags;
    modport master (output input_a, input_a_stb, output_z_ack,
                    input  input_a_ack, output_z, output_z_stb, output_flags);
    modport slave  (input  input_a, input_a_stb, output_z_ack,
                    output input_a_ack, output_z, output_z_stb, output_flags);
endinterface

// File: rtl/fp_sqrt_digit_isqrt_step.sv
// fp_sqrt_digit_isqrt_step: one radix-2 restoring square-root step, producing one root bit.
module fp_sqrt_digit_isqrt_step #(parameter int ROOT_W = 26) (
    input  logic [ROOT_W-1:0] i_rem,
    input  logic [ROOT_W-1:0] i_root,
    input  logic [1:0]        i_bits,
    output logic [ROOT_W+1:0] o_rem,
    output logic [ROOT_W-1:0] o_root
);
    logic [ROOT_W+1:0] w_rem;
    logic [ROOT_W+1:0] w_trial;
    logic              w_fit;
    assign w_rem   = {i_rem, i_bits};
    assign w_trial = {i_root, 2'b01};
    assign w_fit   = w_rem >= w_trial;
    assign o_rem   = w_fit ? w_rem - w_trial : w_rem;
    assign o_root  = {i_root[ROOT_W-2:0], w_fit};
endmodule

// File: rtl/fp_sqrt_digit.sv
// fp_sqrt_digit: IEEE-754 square root, round-to-nearest-even, one root bit per clock.
module fp_sqrt_digit
    import fp_sqrt_digit_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input logic clk,
    input logic rst,
    fp_sqrt_digit_if.slave bus
);
    localparam int W      = 1 + EXP_W + MAN_W;
    localparam int BIAS   = (1 << (EXP_W - 1)) - 1;
    localparam int ROOT_W = MAN_W + 3;
    localparam int RAD_W  = 2 * ROOT_W;
    localparam int E_W    = EXP_W + 2;
    localparam int CNT_W  = $clog2(ROOT_W + 1);
    localparam logic [W-1:0] QNAN = {1'b1, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
    logic [3:0]              r_state;
    logic [W-1:0]            r_a, r_z;
    logic                    r_ack, r_stb, r_carry, r_inexact;
    logic [1:0]              r_flags;
    logic signed [E_W-1:0]   r_exp;
    logic [MAN_W+1:0]        r_man;
    logic [RAD_W-1:0]        r_rad;
    logic [ROOT_W+1:0]       r_rem;
    logic [ROOT_W-1:0]       r_root;
    logic [CNT_W-1:0]        r_cnt;
    logic [MAN_W-1:0]        r_res;
    logic                    w_sign, w_exp_max, w_exp_zero, w_nan, w_zero, w_inf, w_up;
    logic [EXP_W-1:0]        w_exp_f;
    logic [MAN_W-1:0]        w_frac;
    logic [MAN_W+1:0]        w_man_p, w_sum;
    logic [ROOT_W+1:0]       w_rem;
    logic [ROOT_W-1:0]       w_root;
    logic signed [E_W-1:0]   w_half;
    logic [EXP_W-1:0]        w_zexp;
    assign w_sign     = r_a[W-1];
    assign w_exp_f    = r_a[W-2:MAN_W];
    assign w_frac     = r_a[MAN_W-1:0];
    assign w_exp_max  = &w_exp_f;
    assign w_exp_zero = ~|w_exp_f;
    assign w_nan      = w_exp_max && w_frac != '0;
    assign w_zero     = w_exp_zero && w_frac == '0;
    assign w_inf      = w_exp_max && w_frac == '0;
    assign w_man_p    = r_exp[0] ? r_man << 1 : r_man;
    assign w_up       = r_root[1] & (r_root[0] | (r_rem != '0) | r_root[2]);
    assign w_sum      = {1'b0, r_root[ROOT_W-1:2]} + (MAN_W+2)'(w_up);
    // Exponent is even after PREP, so the halving is exact; carry bumps the result exponent.
    assign w_half     = r_exp >>> 1;
    assign w_zexp     = EXP_W'(w_half + E_W'(BIAS) + E_W'(r_carry));
    fp_sqrt_digit_isqrt_step #(.ROOT_W(ROOT_W)) u_step (
        .i_rem  (r_rem[ROOT_W-1:0]),
        .i_root (r_root),
        .i_bits (r_rad[RAD_W-1:RAD_W-2]),
        .o_rem  (w_rem),
        .o_root (w_root)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_GET_A;
            r_ack   <= 1'b0;
            r_stb   <= 1'b0;
            r_z     <= '0;
            r_flags <= '0;
        end else begin
            case (r_state)
                ST_GET_A: begin
                    r_ack <= 1'b1;
                    if (r_ack && bus.input_a_stb) begin
                        r_a     <= bus.input_a;
                        r_ack   <= 1'b0;
                        r_state <= ST_UNPACK;
                    end
                end
                ST_UNPACK: begin
                    r_exp   <= w_exp_zero ? E_W'(1 - BIAS) : E_W'(w_exp_f) - E_W'(BIAS);
                    r_man   <= {1'b0, ~w_exp_zero, w_frac};
                    r_state <= ST_SPECIAL;
                end
                ST_SPECIAL: begin
                    if (w_nan || w_zero || w_sign || w_inf) begin
                        r_z     <= (w_nan || (w_sign && !w_zero)) ? QNAN : r_a;
                        r_flags <= mk_flags(w_nan ? !w_frac[MAN_W-1] : w_sign && !w_zero, 1'b0);
                        r_state <= ST_PUT_Z;
                    end else begin
                        r_state <= ST_NORM;
                    end
                end
                ST_NORM: begin
                    if (r_man[MAN_W]) begin
                        r_state <= ST_PREP;
                    end else begin
                        r_man <= r_man << 1;
                        r_exp <= r_exp - E_W'(1);
                    end
                end
                ST_PREP: begin
                    r_exp   <= r_exp[0] ? r_exp - E_W'(1) : r_exp;
                    r_rad   <= RAD_W'(w_man_p) << (RAD_W - MAN_W - 2);
                    r_rem   <= '0;
                    r_root  <= '0;
                    r_cnt   <= CNT_W'(ROOT_W);
                    r_state <= ST_ITER;
                end
                ST_ITER: begin
                    r_rem   <= w_rem;
                    r_root  <= w_root;
                    r_rad   <= r_rad << 2;
                    r_cnt   <= r_cnt - CNT_W'(1);
                    r_state <= (r_cnt == CNT_W'(1)) ? ST_ROUND : ST_ITER;
                end
                ST_ROUND: begin
                    r_res     <= w_sum[MAN_W+1] ? w_sum[MAN_W:1] : w_sum[MAN_W-1:0];
                    r_carry   <= w_sum[MAN_W+1];
                    r_inexact <= r_root[1] | r_root[0] | (r_rem != '0);
                    r_state   <= ST_PACK;
                end
                ST_PACK: begin
                    r_z     <= {1'b0, w_zexp, r_res};
                    r_flags <= mk_flags(1'b0, r_inexact);
                    r_stb   <= 1'b1;
                    r_state <= ST_PUT_Z;
                end
                ST_PUT_Z: begin
                    if (!r_stb) begin
                        r_stb <= 1'b1;
                    end else if (bus.output_z_ack) begin
                        r_stb   <= 1'b0;
                        r_state <= ST_GET_A;
                    end
                end
                default: r_state <= ST_GET_A;
            endcase
        end
    end
    assign bus.input_a_ack  = r_ack;
    assign bus.output_z     = r_z;
    assign bus.output_z_stb = r_stb;
    assign bus.output_flags = r_flags;
endmodule
